ram_arbiter: RTL and testbench

- Two-port round-robin arbiter sitting directly upstream of the single-port synchronous RAM.
- Lets the CPU (port 0) and a secondary master such as a video fetcher or DMA (port 1) share one RAM instance.
- Converts per-master request/grant handshakes into RAM cs/we/addr/data_in strobes.
- Routes the one-cycle-late read data back to the master that issued the read, with a valid strobe.

---
 rtl/microsys_pkg.sv | 14 +
 rtl/ram_arbiter_rr_arb2.sv | 40 ++++
 rtl/ram_arbiter.sv | 84 ++++++++
 tb/tb_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microsys_pkg.sv
// Shared types and sizing constants for the RAM subsystem.
// The RAM instance and the arbiter both take their widths from RAM_A and RAM_D.
package microsys_pkg;

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_id_e;

  localparam int RAM_A = 10;
  localparam int RAM_D = 8;

  function automatic logic [1:0] port_onehot(port_id_e p);
    return (p == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant in the same cycle as the request,
// with a single priority flop that favours the port that lost the last grant.
module rr_arb2
  import microsys_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_e prio;
  port_id_e prio_next;
  port_id_e winner;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= PORT0;
    end else begin
      prio <= prio_next;
    end
  end

  // A lone requester always wins; on contention the favoured port wins.
  always_comb begin
    gnt       = 2'b00;
    prio_next = prio;
    winner    = prio;
    case (req)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      default: winner = prio;
    endcase
    if (!reset && (req != 2'b00)) begin
      gnt       = port_onehot(winner);
      prio_next = (winner == PORT0) ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two masters, steering the granted
// port onto the RAM strobes and returning read data one cycle later to its owner.
module ram_arbiter
  import microsys_pkg::*;
#(
  parameter int A = RAM_A,
  parameter int D = RAM_D
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [A-1:0] m0_addr,
  input  logic [D-1:0] m0_wdata,
  output logic         m0_gnt,
  output logic         m0_rvalid,
  output logic [D-1:0] m0_rdata,

  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [A-1:0] m1_addr,
  input  logic [D-1:0] m1_wdata,
  output logic         m1_gnt,
  output logic         m1_rvalid,
  output logic [D-1:0] m1_rdata,

  output logic         ram_cs,
  output logic         ram_we,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_wdata,
  input  logic [D-1:0] ram_rdata
);

  logic [1:0] gnt;
  logic [1:0] rd_pend;
  logic [1:0] rd_pend_next;
  port_id_e   sel;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  // The arbiter already forces gnt low during reset, so every strobe follows from it.
  always_comb begin
    sel       = gnt[1] ? PORT1 : PORT0;
    ram_cs    = |gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ram_cs) begin
      if (sel == PORT1) begin
        ram_we    = m1_we;
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
      end else begin
        ram_we    = m0_we;
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
      end
    end
    rd_pend_next = {gnt[1] & ~m1_we, gnt[0] & ~m0_we};
  end

  // Remembers which port owns the read the RAM is answering in the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 2'b00;
    end else begin
      rd_pend <= rd_pend_next;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rd_pend[0];
  assign m1_rvalid = rd_pend[1];
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port synchronous RAM attached.
module tb_ram_arbiter;

  localparam int A = 10;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [A-1:0] m0_addr, m1_addr;
  logic [D-1:0] m0_wdata, m1_wdata;
  logic         m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [D-1:0] m0_rdata, m1_rdata;
  logic         ram_cs, ram_we;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_wdata;
  logic [D-1:0] ram_rdata;

  int   checkCount = 0;
  int   failCount  = 0;
  logic ramInit;
  logic hold0 = 1'b0;
  logic hold1 = 1'b0;
  logic [D-1:0] mem [0:(1<<A)-1];

  ram_arbiter #(.A(A), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: writes land at the edge, read data appears after the edge and holds on writes.
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < (1 << A); i++) mem[i] <= '0;
      mem[1] <= 8'h11;
      mem[2] <= 8'h22;
      mem[3] <= 8'h33;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [A-1:0] a0, input logic [D-1:0] d0,
                               input logic r1, input logic w1, input logic [A-1:0] a1, input logic [D-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // A master must keep req up until it is granted.
  always @(negedge clk) begin
    if (hold0 && !reset) checkOutput("m0_req_held", 32'(m0_req), 1);
    if (hold1 && !reset) checkOutput("m1_req_held", 32'(m1_req), 1);
    hold0 = m0_req && !m0_gnt && !reset;
    hold1 = m1_req && !m1_gnt && !reset;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    ramInit = 1'b1;
    applyStimulus(1'b1, 1'b1, 10'h012, 8'hAA, 1'b1, 1'b1, 10'h020, 8'h55);
    nextCycle();
    ramInit = 1'b0;
    @(negedge clk);
    checkOutput("rst_m0_gnt",    32'(m0_gnt),    0);
    checkOutput("rst_m1_gnt",    32'(m1_gnt),    0);
    checkOutput("rst_ram_cs",    32'(ram_cs),    0);
    checkOutput("rst_ram_we",    32'(ram_we),    0);
    checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 0);
    checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 0);

    // Single master: write then read back.
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 10'h012, 8'h5A, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("sm_wr_m0_gnt", 32'(m0_gnt),    1);
    checkOutput("sm_wr_m1_gnt", 32'(m1_gnt),    0);
    checkOutput("sm_wr_cs",     32'(ram_cs),    1);
    checkOutput("sm_wr_we",     32'(ram_we),    1);
    checkOutput("sm_wr_addr",   32'(ram_addr),  'h012);
    checkOutput("sm_wr_wdata",  32'(ram_wdata), 'h5A);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h012, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("sm_rd_m0_gnt", 32'(m0_gnt),    1);
    checkOutput("sm_rd_we",     32'(ram_we),    0);
    checkOutput("sm_rd_addr",   32'(ram_addr),  'h012);
    checkOutput("sm_rd_early",  32'(m0_rvalid), 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("sm_m0_rvalid", 32'(m0_rvalid), 1);
    checkOutput("sm_m0_rdata",  32'(m0_rdata),  'h5A);
    checkOutput("sm_m1_rvalid", 32'(m1_rvalid), 0);
    checkOutput("sm_idle_cs",   32'(ram_cs),    0);

    // Reset asserted mid-cycle while m0 is being granted.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h000, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("mr_pre_m0_gnt", 32'(m0_gnt), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mr_m0_gnt",    32'(m0_gnt),    0);
    checkOutput("mr_ram_cs",    32'(ram_cs),    0);
    checkOutput("mr_m0_rvalid", 32'(m0_rvalid), 0);
    checkOutput("mr_m1_rvalid", 32'(m1_rvalid), 0);

    // Ordering: write 0xC3 @0x3FF from m0 against a read of 0x3FF from m1.
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 10'h3FF, 8'hC3, 1'b1, 1'b0, 10'h3FF, '0);
    @(negedge clk);
    checkOutput("ord_m0_gnt", 32'(m0_gnt),    1);
    checkOutput("ord_m1_gnt", 32'(m1_gnt),    0);
    checkOutput("ord_we",     32'(ram_we),    1);
    checkOutput("ord_addr",   32'(ram_addr),  'h3FF);
    checkOutput("ord_wdata",  32'(ram_wdata), 'hC3);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0);
    @(negedge clk);
    checkOutput("ord2_m1_gnt", 32'(m1_gnt),   1);
    checkOutput("ord2_m0_gnt", 32'(m0_gnt),   0);
    checkOutput("ord2_we",     32'(ram_we),   0);
    checkOutput("ord2_addr",   32'(ram_addr), 'h3FF);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("ord_m1_rvalid", 32'(m1_rvalid), 1);
    checkOutput("ord_m1_rdata",  32'(m1_rdata),  'hC3);
    checkOutput("ord_m0_rvalid", 32'(m0_rvalid), 0);

    // Contention: both masters read for six cycles, then m0 takes one more.
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 10'h012, '0, (i < 6), 1'b0, 10'h3FF, '0);
      @(negedge clk);
      checkOutput("cont_m0_gnt", 32'(m0_gnt), (i % 2 == 0) ? 1 : 0);
      checkOutput("cont_m1_gnt", 32'(m1_gnt), (i % 2 == 1) ? 1 : 0);
      checkOutput("cont_addr",   32'(ram_addr), (i % 2 == 0) ? 'h012 : 'h3FF);
      if (i > 0) begin
        checkOutput("cont_m0_rvalid", 32'(m0_rvalid), ((i - 1) % 2 == 0) ? 1 : 0);
        checkOutput("cont_m1_rvalid", 32'(m1_rvalid), ((i - 1) % 2 == 1) ? 1 : 0);
        if ((i - 1) % 2 == 0) checkOutput("cont_m0_rdata", 32'(m0_rdata), 'h5A);
        else                  checkOutput("cont_m1_rdata", 32'(m1_rdata), 'hC3);
      end
    end
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("cont_tail_m0_rvalid", 32'(m0_rvalid), 1);
    checkOutput("cont_tail_m0_rdata",  32'(m0_rdata),  'h5A);
    checkOutput("cont_tail_m1_rvalid", 32'(m1_rvalid), 0);

    // Back-to-back m1 reads of preloaded words.
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if (i < 3) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, A'(i + 1), '0);
      else       idle();
      @(negedge clk);
      checkOutput("b2b_m1_gnt",    32'(m1_gnt),    (i < 3) ? 1 : 0);
      checkOutput("b2b_m1_rvalid", 32'(m1_rvalid), (i > 0) ? 1 : 0);
      checkOutput("b2b_m0_rvalid", 32'(m0_rvalid), 0);
      if (i > 0) checkOutput("b2b_m1_rdata", 32'(m1_rdata), 'h11 * i);
    end

    // A write right after a read still delivers the read response.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h003, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("rw_m0_gnt", 32'(m0_gnt), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h004, 8'h44);
    @(negedge clk);
    checkOutput("rw_m1_gnt",    32'(m1_gnt),    1);
    checkOutput("rw_we",        32'(ram_we),    1);
    checkOutput("rw_m0_rvalid", 32'(m0_rvalid), 1);
    checkOutput("rw_m0_rdata",  32'(m0_rdata),  'h33);
    checkOutput("rw_m1_rvalid", 32'(m1_rvalid), 0);

    // Reset lands between a read grant and its response edge.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h012, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("rp_m0_gnt", 32'(m0_gnt), 1);
    #2;
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("rp_dropped_rvalid", 32'(m0_rvalid), 0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'h012, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checkOutput("rp_post_m0_gnt", 32'(m0_gnt), 1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("rp_post_rvalid", 32'(m0_rvalid), 1);
    checkOutput("rp_post_rdata",  32'(m0_rdata),  'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
